// File: rtl/rom_match_pkg.sv
// Shared definitions for the ROM-match engine: ROM table, field widths, FSM encoding
// and the match predicate used during a scan.
package rom_match_pkg;

  localparam int R_W         = 8;
  localparam int ROR_W       = 4;
  localparam int ID_W        = 3;
  localparam int ROM_ENTRIES = 8;
  localparam int MAR_W       = $clog2(ROM_ENTRIES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_SCAN = ST_SCAN,
    S_DONE = ST_DONE
  } state_e;

  typedef struct packed {
    logic [R_W-1:0]   r1;
    logic [R_W-1:0]   r2;
    logic [ROR_W-1:0] ror;
  } rom_entry_t;

  localparam rom_entry_t ROM_TABLE [ROM_ENTRIES] = '{
    '{r1: 8'h7F, r2: 8'h97, ror: 4'hA},
    '{r1: 8'h39, r2: 8'hD6, ror: 4'h2},
    '{r1: 8'hA8, r2: 8'hFF, ror: 4'hF},
    '{r1: 8'hFF, r2: 8'h6B, ror: 4'hA},
    '{r1: 8'hFF, r2: 8'hF6, ror: 4'hE},
    '{r1: 8'hFF, r2: 8'hBA, ror: 4'h8},
    '{r1: 8'hCA, r2: 8'h75, ror: 4'hB},
    '{r1: 8'h2F, r2: 8'hFF, ror: 4'h4}
  };

  // An entry hits when every operand bit is covered by its row pattern.
  function automatic logic entry_match(input rom_entry_t e, input logic [R_W-1:0] x);
    return ((e.r2 & ~x) | (e.r1 & x) | (e.r1 & e.r2)) == {R_W{1'b1}};
  endfunction

endpackage

// File: rtl/rom_match_sched_if.sv
// Bus bundle for rom_match_sched: requester side (req/din/ack), result side (res_*) and busy.
interface rom_match_sched_if
  import rom_match_pkg::*;
#(parameter int NREQ = 4);

  logic [NREQ-1:0]          req;
  logic [NREQ-1:0][R_W-1:0] din;
  logic [NREQ-1:0]          ack;
  logic                     res_valid;
  logic                     res_ready;
  logic [ROR_W-1:0]         res_data;
  logic [ID_W-1:0]          res_id;
  logic                     busy;

  modport master (
    output req, din, res_ready,
    input  ack, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req, din, res_ready,
    output ack, res_valid, res_data, res_id, busy
  );

endinterface

// File: rtl/rom_match_rr_arb.sv
// Round-robin arbiter: ptr names the requester with highest priority this round;
// the first active request at or after ptr (wrapping) wins.
module rom_match_rr_arb
  import rom_match_pkg::*;
#(parameter int NREQ = 4) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req[k] && (k == ((int'(ptr) + i) % NREQ))) begin
          found    = 1'b1;
          grant[k] = 1'b1;
          idx      = ID_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/rom_match_sched.sv
// ROM-match scheduler: grants one requester round-robin, scans the ROM against its operand
// and presents the OR of hit entries. Define ROM_MATCH_EARLY_EXIT_EN to stop once saturated.
module rom_match_sched
  import rom_match_pkg::*;
#(parameter int NREQ = 4) (
  input logic              clk,
  input logic              rst_n,
  rom_match_sched_if.slave bus
);

  localparam logic [MAR_W-1:0] MAR_LAST = MAR_W'(ROM_ENTRIES - 1);

  logic [1:0]       state;
  logic [R_W-1:0]   in_r;
  logic [ROR_W-1:0] acc;
  logic [MAR_W-1:0] mar;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  id_r;

  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  ptr_nxt;
  logic [R_W-1:0]   din_sel;
  logic             hit;
  logic [ROR_W-1:0] acc_nxt;
  logic             scan_end;

  rom_match_rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gnt_idx)
  );

  always_comb begin
    din_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) din_sel = din_sel | bus.din[k];
    end
  end

  assign ptr_nxt = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  assign hit     = entry_match(ROM_TABLE[mar], in_r);
  assign acc_nxt = hit ? (acc | ROM_TABLE[mar].ror) : acc;

`ifdef ROM_MATCH_EARLY_EXIT_EN
  assign scan_end = (mar == MAR_LAST) || (acc_nxt == {ROR_W{1'b1}});
`else
  assign scan_end = (mar == MAR_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      in_r  <= '0;
      acc   <= '0;
      mar   <= '0;
      ptr   <= '0;
      id_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            in_r  <= din_sel;
            acc   <= '0;
            mar   <= '0;
            id_r  <= gnt_idx;
            ptr   <= ptr_nxt;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          acc <= acc_nxt;
          if (scan_end) state <= ST_DONE;
          else          mar   <= mar + MAR_W'(1);
        end
        ST_DONE: begin
          if (bus.res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ack is the arbiter's combinational grant, so it pulses in the very cycle din is sampled.
  assign bus.ack       = (rst_n && (state == ST_IDLE)) ? grant : '0;
  assign bus.res_valid = (state == ST_DONE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.res_data  = acc;
  assign bus.res_id    = id_r;

endmodule

// File: tb/tb_rom_match_sched.sv
// Self-checking bench for rom_match_sched: transaction-level scoreboard model fed by
// directed scenarios followed by randomized request/ready/reset traffic.
module tb_rom_match_sched;

  localparam int NREQ = 4;
`ifdef ROM_MATCH_EARLY_EXIT_EN
  localparam int LAT_ZERO = 4;
`else
  localparam int LAT_ZERO = 9;
`endif

  localparam logic [7:0] REF_R1  [8] = '{8'h7F, 8'h39, 8'hA8, 8'hFF, 8'hFF, 8'hFF, 8'hCA, 8'h2F};
  localparam logic [7:0] REF_R2  [8] = '{8'h97, 8'hD6, 8'hFF, 8'h6B, 8'hF6, 8'hBA, 8'h75, 8'hFF};
  localparam logic [3:0] REF_ROR [8] = '{4'hA, 4'h2, 4'hF, 4'hA, 4'hE, 4'h8, 4'hB, 4'h4};

  typedef struct {
    logic [3:0] data;
    logic [2:0] id;
    int         first;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  exp_t exp_q[$];
  logic m_busy       = 1'b0;
  int   m_ptr        = 0;
  int   m_valid_from = 0;
  logic seen_first   = 1'b0;

  rom_match_sched_if #(.NREQ(NREQ)) bus ();

  rom_match_sched #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int req_v);
    n_checks++;
    if (act != req_v) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  // Result = OR of every entry whose row selected by each operand bit is all ones.
  function automatic void refResult(input logic [7:0] x, output logic [3:0] data, output int lat);
    logic [7:0] r1;
    logic [7:0] r2;
    logic       hit;
    data = 4'h0;
    lat  = 9;
    for (int k = 0; k < 8; k++) begin
      r1  = REF_R1[k];
      r2  = REF_R2[k];
      hit = 1'b1;
      for (int b = 0; b < 8; b++) begin
        if (!(x[b] ? r1[b] : r2[b])) hit = 1'b0;
      end
      if (hit) data = data | REF_ROR[k];
`ifdef ROM_MATCH_EARLY_EXIT_EN
      if (data == 4'hF && lat == 9) lat = k + 2;
`endif
    end
  endfunction

  // Reference model: one engine, round-robin pointer, result due lat cycles after grant.
  always @(negedge clk) begin : model
    logic [NREQ-1:0] exp_ack;
    logic            exp_valid;
    logic            nxt_busy;
    logic            granted;
    logic [3:0]      d;
    int              lat;
    int              g;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      exp_q.delete();
      checkOutput("rst_ack", int'(bus.ack), 0);
      checkOutput("rst_res_valid", int'(bus.res_valid), 0);
      checkOutput("rst_busy", int'(bus.busy), 0);
      checkOutput("rst_res_data", int'(bus.res_data), 0);
      checkOutput("rst_res_id", int'(bus.res_id), 0);
    end else begin
      exp_valid = m_busy && (cyc >= m_valid_from);
      exp_ack   = '0;
      granted   = 1'b0;
      nxt_busy  = m_busy;
      if (!m_busy) begin
        for (int i = 0; i < NREQ; i++) begin
          g = (m_ptr + i) % NREQ;
          if (!granted && bus.req[g]) begin
            granted    = 1'b1;
            exp_ack[g] = 1'b1;
            refResult(bus.din[g], d, lat);
            exp_q.push_back('{data: d, id: 3'(g), first: cyc + lat});
            m_valid_from = cyc + lat;
            m_ptr        = (g + 1) % NREQ;
            nxt_busy     = 1'b1;
          end
        end
      end
      if (exp_valid && bus.res_ready) nxt_busy = 1'b0;
      checkOutput("ack", int'(bus.ack), int'(exp_ack));
      checkOutput("res_valid", int'(bus.res_valid), int'(exp_valid));
      checkOutput("busy", int'(bus.busy), int'(m_busy));
      m_busy = nxt_busy;
    end
  end

  always @(negedge clk) begin : monitor
    if (!rst_n) begin
      seen_first = 1'b0;
    end else if (bus.res_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("res_unexpected", 1, 0);
      end else begin
        checkOutput("res_data", int'(bus.res_data), int'(exp_q[0].data));
        checkOutput("res_id", int'(bus.res_id), int'(exp_q[0].id));
        if (!seen_first) begin
          checkOutput("res_latency", cyc, exp_q[0].first);
          seen_first = 1'b1;
        end
        if (bus.res_ready) begin
          void'(exp_q.pop_front());
          seen_first = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0][7:0] dv,
                               input logic rdy);
    @(posedge clk);
    #1;
    bus.req       = r;
    bus.din       = dv;
    bus.res_ready = rdy;
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic waitAck(input int bound, output logic [NREQ-1:0] a);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack == '0 && n < bound);
    a = bus.ack;
  endtask

  task automatic waitValid(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < bound);
  endtask

  initial begin
    logic [NREQ-1:0]      a;
    logic [NREQ-1:0]      r;
    logic [NREQ-1:0][7:0] d;
    logic [3:0]           rd;
    int                   n;
    int                   lat;
    bus.req       = '0;
    bus.din       = '0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Operand FF hits entries 3,4,5 -> E from requester 0.
    d = '0;
    d[0] = 8'hFF;
    applyStimulus(4'b0001, d, 1'b1);
    waitAck(5, a);
    checkOutput("t1_ack", int'(a), 1);
    applyStimulus(4'b0000, d, 1'b1);
    waitValid(20, n);
    checkOutput("t1_latency", n, 9);
    checkOutput("t1_data", int'(bus.res_data), 4'hE);
    checkOutput("t1_id", int'(bus.res_id), 0);

    // Operand 00 hits entries 2,7 -> F from requester 1.
    d[1] = 8'h00;
    applyStimulus(4'b0010, d, 1'b1);
    waitAck(5, a);
    checkOutput("t2_ack", int'(a), 2);
    applyStimulus(4'b0000, d, 1'b1);
    waitValid(20, n);
    checkOutput("t2_latency", n, LAT_ZERO);
    checkOutput("t2_data", int'(bus.res_data), 4'hF);
    checkOutput("t2_id", int'(bus.res_id), 1);

    // Round-robin ordering: 0, 2, then 3, 0, 1.
    applyReset();
    for (int i = 0; i < NREQ; i++) d[i] = 8'($urandom);
    applyStimulus(4'b0101, d, 1'b1);
    waitAck(5, a);
    checkOutput("t3_ack0", int'(a), 4'b0001);
    applyStimulus(4'b0100, d, 1'b1);
    waitAck(30, a);
    checkOutput("t3_ack2", int'(a), 4'b0100);
    applyStimulus(4'b1011, d, 1'b1);
    waitAck(30, a);
    checkOutput("t3_ack3", int'(a), 4'b1000);
    applyStimulus(4'b0011, d, 1'b1);
    waitAck(30, a);
    checkOutput("t3_ack0b", int'(a), 4'b0001);
    applyStimulus(4'b0010, d, 1'b1);
    waitAck(30, a);
    checkOutput("t3_ack1", int'(a), 4'b0010);
    applyStimulus(4'b0000, d, 1'b1);
    waitValid(20, n);

    // Backpressure: DONE held with req[3] pending.
    d[3] = 8'($urandom);
    refResult(d[3], rd, lat);
    applyStimulus(4'b1000, d, 1'b1);
    waitAck(30, a);
    checkOutput("t4_ack", int'(a), 4'b1000);
    applyStimulus(4'b1000, d, 1'b0);
    waitValid(20, n);
    checkOutput("t4_latency", n, lat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("t4_hold_ack", int'(bus.ack), 0);
      checkOutput("t4_hold_valid", int'(bus.res_valid), 1);
      checkOutput("t4_hold_data", int'(bus.res_data), int'(rd));
    end
    applyStimulus(4'b1000, d, 1'b1);
    waitAck(5, a);
    checkOutput("t4_ack_after", int'(a), 4'b1000);
    applyStimulus(4'b0000, d, 1'b1);
    waitValid(20, n);

    // Reset in the middle of a scan (mar=4).
    d[2] = 8'h00;
    applyStimulus(4'b0100, d, 1'b1);
    waitAck(30, a);
    checkOutput("t5_ack", int'(a), 4'b0100);
    applyStimulus(4'b0000, d, 1'b1);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t5_rst_valid", int'(bus.res_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checkOutput("t5_no_valid", int'(bus.res_valid), 0);
    end
    applyStimulus(4'b1111, d, 1'b1);
    waitAck(5, a);
    checkOutput("t5_ack_after_rst", int'(a), 4'b0001);
    applyStimulus(4'b0000, d, 1'b1);
    waitValid(20, n);

    // Randomized traffic; the model and monitor check every cycle.
    r = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
        case ($urandom_range(0, 3))
          0:       d[i] = 8'hFF;
          1:       d[i] = 8'h00;
          default: d[i] = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 399) == 0) applyReset();
      else applyStimulus(r, d, ($urandom_range(0, 3) != 0));
    end

    applyStimulus(4'b0000, d, 1'b1);
    repeat (30) @(negedge clk);
    checkOutput("drain_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
